flash_audio_sequencer: RTL and testbench

Playback sequencer between the keyboard control FSM and the flash memory read port. It walks the flash address space forward or backward under `start_reading`/`direction` control, performs one read handshake per 32-bit word, and releases the two 16-bit samples in each word to the audio path on successive sample-rate ticks. It also handles wrap-around at the song boundaries and restart requests.

---
 rtl/flash_audio_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_flash_audio_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_audio_sequencer.sv
// flash_audio_sequencer
//
// Playback sequencer between the keyboard control FSM and the flash read port.
// It walks the flash word address space forward or backward, does one read
// handshake per 32-bit word, and releases the two 16-bit samples of each word
// on successive sample-rate ticks. Wraps at the song boundaries and honours
// restart requests without ever abandoning a bus handshake.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   -> WAIT_DATA gives up after TIMEOUT cycles without data and
//                reissues the read at the same address.
//   undefined -> WAIT_DATA waits indefinitely; TIMEOUT is unused.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start_reading         1 = play, 0 = pause
//   direction             1 = forward, 0 = backward
//   restart               one-cycle pulse, return to the song start
//   sample_tick           one-cycle pulse at the sample rate (synchronous)
//   flash_read            read request, held until waitrequest drops
//   flash_address         word address of the request
//   flash_byteenable      constant 4'hF
//   flash_waitrequest     slave not ready
//   flash_readdata        read word
//   flash_readdatavalid   flash_readdata valid this cycle
//   audio_data            current sample (registered)
//   audio_valid           one-cycle pulse when audio_data updates

module flash_audio_sequencer #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF,
  parameter int                TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_reading,
  input  logic              direction,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  output logic [3:0]        flash_byteenable,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_data,
  output logic              audio_valid
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    SAMPLE0,
    SAMPLE1,
    ADVANCE
  } state_t;

  state_t      state;
  logic [31:0] word;
  logic        dir_q;
  logic        restart_pend;
  logic        consume;
  logic        restart_any;

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign flash_byteenable = 4'hF;
  assign consume          = start_reading & sample_tick;
  // A restart arriving this very cycle is honoured together with a latched one.
  assign restart_any      = restart | restart_pend;

  function automatic logic [ADDR_W-1:0] song_start(input logic fwd);
    return fwd ? '0 : LAST_ADDR;
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic              fwd);
    if (fwd) return (a == LAST_ADDR) ? '0 : a + 1'b1;
    else     return (a == '0) ? LAST_ADDR : a - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      flash_read    <= 1'b0;
      flash_address <= '0;
      audio_data    <= 16'h0000;
      audio_valid   <= 1'b0;
      restart_pend  <= 1'b0;
      dir_q         <= 1'b1;
      word          <= 32'h0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      audio_valid <= 1'b0;
      // Latch every restart; states that act on it clear it below.
      if (restart) restart_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (restart_any) begin
            flash_address <= song_start(direction);
            restart_pend  <= 1'b0;
          end
          if (start_reading) begin
            state      <= REQ;
            flash_read <= 1'b1;
          end
        end

        REQ: begin
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            state      <= WAIT_DATA;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end

        WAIT_DATA: begin
          if (flash_readdatavalid) begin
            word  <= flash_readdata;
            dir_q <= direction;
            // A restart during the fetch discards the word once it lands.
            state <= restart_any ? ADVANCE : SAMPLE0;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            state      <= REQ;
            flash_read <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        SAMPLE0: begin
          if (restart) begin
            state <= ADVANCE;
          end else if (consume) begin
            audio_data  <= dir_q ? word[15:0] : word[31:16];
            audio_valid <= 1'b1;
            state       <= SAMPLE1;
          end
        end

        SAMPLE1: begin
          if (restart) begin
            state <= ADVANCE;
          end else if (consume) begin
            audio_data  <= dir_q ? word[31:16] : word[15:0];
            audio_valid <= 1'b1;
            state       <= ADVANCE;
          end
        end

        ADVANCE: begin
          if (restart_any) begin
            flash_address <= song_start(direction);
            restart_pend  <= 1'b0;
          end else begin
            flash_address <= step_addr(flash_address, direction);
          end
          flash_read <= start_reading;
          state      <= start_reading ? REQ : IDLE;
        end

        default: begin
          state      <= IDLE;
          flash_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// tb_flash_audio_sequencer
//
// Bench for flash_audio_sequencer: a cycle-accurate vector table for the
// basic play/wrap/wait-state/pause sequences, hand-written restart (and, with
// SEQ_TIMEOUT_EN, timeout) sequences, and randomized playback against a
// transaction-level model of the address walk and sample stream.

module tb_flash_audio_sequencer;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_reading = 1'b0;
  logic        direction = 1'b1;
  logic        restart = 1'b0;
  logic        sample_tick = 1'b0;

  // Table-driven and behavioural-slave drivers of the flash response lines.
  logic        auto_slave = 1'b0;
  logic        t_wr = 1'b0, t_rv = 1'b0;
  logic [31:0] t_rd = 32'h0;
  logic        s_wr = 1'b0, s_rv = 1'b0;
  logic [31:0] s_rd = 32'h0;

  wire         flash_waitrequest   = auto_slave ? s_wr : t_wr;
  wire         flash_readdatavalid = auto_slave ? s_rv : t_rv;
  wire  [31:0] flash_readdata      = auto_slave ? s_rd : t_rd;

  logic        flash_read;
  logic [22:0] flash_address;
  logic [3:0]  flash_byteenable;
  logic [15:0] audio_data;
  logic        audio_valid;

  int total = 0;
  int bad   = 0;

  // Slave tuning and scoreboard state.
  int          wait_pct = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  logic        sb_on    = 1'b0;
  logic [22:0] model_addr = '0;
  logic [15:0] exp_q[$];
  int          consumed = 0;

  flash_audio_sequencer dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start_reading       (start_reading),
    .direction           (direction),
    .restart             (restart),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_byteenable    (flash_byteenable),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] song_step(input logic [22:0] a, input logic fwd);
    if (fwd) return (a == LAST) ? 23'd0 : a + 23'd1;
    else     return (a == 23'd0) ? LAST : a - 23'd1;
  endfunction

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        dir;
    logic        tick;
    logic        wr;
    logic        rv;
    logic [31:0] rd;
    logic        exp_read;
    logic [22:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic start, input logic dir,
                              input logic tick, input logic wr, input logic rv,
                              input logic [31:0] rd, input logic er,
                              input logic [22:0] ea, input logic ev,
                              input logic [15:0] ed);
    vec_t v;
    v.rst = rst; v.start = start; v.dir = dir; v.tick = tick; v.wr = wr; v.rv = rv;
    v.rd = rd; v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    reset_n       = ~v.rst;
    start_reading = v.start;
    direction     = v.dir;
    sample_tick   = v.tick;
    t_wr          = v.wr;
    t_rv          = v.rv;
    t_rd          = v.rd;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    check_val($sformatf("vec%0d.read", idx),  {31'd0, flash_read},   {31'd0, v.exp_read});
    check_val($sformatf("vec%0d.addr", idx),  {9'd0, flash_address}, {9'd0, v.exp_addr});
    check_val($sformatf("vec%0d.valid", idx), {31'd0, audio_valid},  {31'd0, v.exp_valid});
    check_val($sformatf("vec%0d.data", idx),  {16'd0, audio_data},   {16'd0, v.exp_data});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    start_reading = 1'b0;
    restart       = 1'b0;
    sample_tick   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Behavioural flash slave: random wait states, one outstanding read,
  // configurable data latency, garbage on the data bus when not valid.
  initial begin : slave
    logic        pend;
    int          cnt;
    logic [31:0] pend_data;
    pend = 1'b0;
    cnt  = 0;
    pend_data = 32'h0;
    forever begin
      @(negedge clk);
      s_rv = 1'b0;
      s_rd = $urandom;
      if (!reset_n || !auto_slave) begin
        pend = 1'b0;
        s_wr = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            s_rv = 1'b1;
            s_rd = pend_data;
            pend = 1'b0;
          end
        end
        s_wr = (wait_pct > 0) ? ($urandom_range(0, 99) < wait_pct) : 1'b0;
        if (flash_read && !s_wr && !pend) begin
          pend      = 1'b1;
          cnt       = $urandom_range(lat_min, lat_max);
          pend_data = $urandom;
          if (sb_on) begin
            check_val("rand.addr", {9'd0, flash_address}, {9'd0, model_addr});
            model_addr = song_step(model_addr, direction);
            if (direction) begin
              exp_q.push_back(pend_data[15:0]);
              exp_q.push_back(pend_data[31:16]);
            end else begin
              exp_q.push_back(pend_data[31:16]);
              exp_q.push_back(pend_data[15:0]);
            end
          end
        end
      end
    end
  end

  // Audio monitor: every sample must follow a consumed tick and match the
  // next half-word of the fetched stream.
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_on && audio_valid) begin
        check_val("rand.tick", {31'd0, sample_tick & start_reading}, 32'd1);
        if (exp_q.size() == 0) begin
          check_val("rand.unexpected_sample", {16'd0, audio_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("rand.sample", {16'd0, audio_data}, {16'd0, e});
          consumed++;
        end
      end
    end
  end

  task automatic run_restart(input logic dir_at_restart, input logic [22:0] exp_addr,
                             input string name);
    bit found;
    int valids;
    bit reissued;
    auto_slave = 1'b1;
    sb_on      = 1'b0;
    wait_pct   = 0;
    lat_min    = 3;
    lat_max    = 3;
    do_reset();
    direction     = 1'b1;
    start_reading = 1'b1;
    sample_tick   = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (flash_read && flash_address == 23'h100) found = 1'b1;
    end
    check_val({name, ".reach_0x100"}, {31'd0, found}, 32'd1);
    if (found) begin
      @(negedge clk);
      restart   = 1'b1;
      direction = dir_at_restart;
      @(negedge clk);
      restart = 1'b0;
      valids   = 0;
      reissued = 1'b0;
      for (int c = 0; c < 40 && !reissued; c++) begin
        @(posedge clk);
        #1;
        if (audio_valid) valids++;
        if (flash_read) reissued = 1'b1;
      end
      check_val({name, ".reissued"}, {31'd0, reissued}, 32'd1);
      check_val({name, ".no_audio"}, valids, 32'd0);
      check_val({name, ".addr"}, {9'd0, flash_address}, {9'd0, exp_addr});
    end
    start_reading = 1'b0;
    sample_tick   = 1'b0;
  endtask

  task automatic run_random(input logic dir);
    auto_slave = 1'b1;
    sb_on      = 1'b0;
    wait_pct   = 30;
    lat_min    = 1;
    lat_max    = 4;
    do_reset();
    exp_q.delete();
    model_addr    = '0;
    consumed      = 0;
    direction     = dir;
    start_reading = 1'b1;
    sb_on         = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sample_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) start_reading = ~start_reading;
    end
    @(negedge clk);
    sb_on         = 1'b0;
    start_reading = 1'b0;
    sample_tick   = 1'b0;
    check_val(dir ? "rand_fwd.progress" : "rand_bwd.progress", {31'd0, consumed > 20}, 32'd1);
    check_val(dir ? "rand_fwd.leftover" : "rand_bwd.leftover", {31'd0, exp_q.size() <= 2}, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    vec_t tbl[36];

    repeat (3) @(posedge clk);
    #1;
    check_val("reset.read",  {31'd0, flash_read},   32'd0);
    check_val("reset.addr",  {9'd0, flash_address}, 32'd0);
    check_val("reset.valid", {31'd0, audio_valid},  32'd0);
    check_val("reset.data",  {16'd0, audio_data},   32'd0);
    check_val("byteenable",  {28'd0, flash_byteenable}, 32'hF);
    @(negedge clk);
    reset_n = 1'b1;

    //            rst st dir tk wr rv rd            rd? addr valid data
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, 23'd0, 0, 16'h0000);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, 23'd0, 0, 16'h0000);
    tbl[2]  = mk(0, 1, 1, 1, 0, 1, 32'hBBBB_AAAA, 0, 23'd0, 0, 16'h0000);
    tbl[3]  = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, 23'd0, 1, 16'hAAAA);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 23'd0, 0, 16'hAAAA);
    tbl[5]  = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, 23'd0, 1, 16'hBBBB);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, 23'd1, 0, 16'hBBBB);
    tbl[7]  = mk(0, 1, 1, 0, 1, 0, 32'h0,         1, 23'd1, 0, 16'hBBBB);
    tbl[8]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 23'd1, 0, 16'hBBBB);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 23'd1, 0, 16'hBBBB);
    tbl[10] = mk(1, 1, 1, 0, 0, 0, 32'h0,         0, 23'd0, 0, 16'h0000);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 32'h0,         1, 23'd0, 0, 16'h0000);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 23'd0, 0, 16'h0000);
    tbl[13] = mk(0, 1, 0, 0, 0, 1, 32'h2222_1111, 0, 23'd0, 0, 16'h0000);
    tbl[14] = mk(0, 1, 0, 1, 0, 0, 32'h0,         0, 23'd0, 1, 16'h2222);
    tbl[15] = mk(0, 1, 0, 1, 0, 0, 32'h0,         0, 23'd0, 1, 16'h1111);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 32'h0,         1, LAST,  0, 16'h1111);
    tbl[17] = mk(0, 1, 1, 0, 1, 0, 32'h0,         1, LAST,  0, 16'h1111);
    tbl[18] = mk(0, 1, 1, 0, 1, 0, 32'h0,         1, LAST,  0, 16'h1111);
    tbl[19] = mk(0, 1, 1, 0, 1, 0, 32'h0,         1, LAST,  0, 16'h1111);
    tbl[20] = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, LAST,  0, 16'h1111);
    tbl[21] = mk(0, 1, 1, 0, 0, 1, 32'h1234_5678, 0, LAST,  0, 16'h1111);
    tbl[22] = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, LAST,  1, 16'h5678);
    tbl[23] = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, LAST,  1, 16'h1234);
    tbl[24] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, 23'd0, 0, 16'h1234);
    tbl[25] = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 23'd0, 0, 16'h1234);
    tbl[26] = mk(0, 1, 1, 0, 0, 1, 32'hCAFE_BEEF, 0, 23'd0, 0, 16'h1234);
    tbl[27] = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, 23'd0, 1, 16'hBEEF);
    tbl[28] = mk(0, 0, 1, 1, 0, 0, 32'h0,         0, 23'd0, 0, 16'hBEEF);
    tbl[29] = mk(0, 0, 1, 0, 0, 0, 32'h0,         0, 23'd0, 0, 16'hBEEF);
    tbl[30] = mk(0, 0, 1, 1, 0, 0, 32'h0,         0, 23'd0, 0, 16'hBEEF);
    tbl[31] = mk(0, 0, 1, 1, 0, 0, 32'h0,         0, 23'd0, 0, 16'hBEEF);
    tbl[32] = mk(0, 0, 1, 1, 0, 0, 32'h0,         0, 23'd0, 0, 16'hBEEF);
    tbl[33] = mk(0, 0, 1, 1, 0, 0, 32'h0,         0, 23'd0, 0, 16'hBEEF);
    tbl[34] = mk(0, 1, 1, 1, 0, 0, 32'h0,         0, 23'd0, 1, 16'hCAFE);
    tbl[35] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, 23'd1, 0, 16'hCAFE);

    for (int i = 0; i < 36; i++) begin
      apply_stimulus(tbl[i]);
      check_output(tbl[i], i);
    end

    run_restart(1'b1, 23'd0, "restart_fwd");
    run_restart(1'b0, LAST,  "restart_bwd");

`ifdef SEQ_TIMEOUT_EN
    auto_slave = 1'b0;
    t_wr = 1'b0;
    t_rv = 1'b0;
    do_reset();
    start_reading = 1'b1;
    direction     = 1'b1;
    @(posedge clk);
    #1;
    check_val("timeout.first_read", {31'd0, flash_read}, 32'd1);
    @(posedge clk);
    #1;
    check_val("timeout.accepted", {31'd0, flash_read}, 32'd0);
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      if (k == 255) check_val("timeout.still_waiting", {31'd0, flash_read}, 32'd0);
      if (k == 256) begin
        check_val("timeout.reissue", {31'd0, flash_read}, 32'd1);
        check_val("timeout.addr", {9'd0, flash_address}, 32'd0);
      end
    end
    start_reading = 1'b0;
`endif

    run_random(1'b1);
    run_random(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
